// File: rtl/mcl_host_endpoint_if.sv
// mcl_host_endpoint_if
//   Bundles the host-side and link-side packet handshakes of one mcl endpoint.
//   Signal names are from the endpoint's point of view (_i = into the endpoint).
//
//   Handshake rules:
//     host request : a packet moves when host_v_i & host_ready_o in the same cycle.
//     link request : a packet moves when link_v_o & link_ready_i in the same cycle.
//     link response: a packet moves when link_v_i & link_ready_o in the same cycle.
//     host response: valid/yumi. host_v_o offers the head packet and host_yumi_i
//                    consumes it in that cycle; yumi is only legal while host_v_o=1.
//   A valid, once raised, does not depend on the partner's ready/yumi in that cycle.
//
//   Modports
//     slave  : the endpoint (mcl_host_endpoint)
//     master : the environment driving host and link stimulus
interface mcl_host_endpoint_if #(
  parameter int data_width_p = 80
);
  logic                    host_v_i;
  logic [data_width_p-1:0] host_data_i;
  logic                    host_ready_o;
  logic                    host_v_o;
  logic [data_width_p-1:0] host_data_o;
  logic                    host_yumi_i;
  logic                    link_v_o;
  logic [data_width_p-1:0] link_data_o;
  logic                    link_ready_i;
  logic                    link_v_i;
  logic [data_width_p-1:0] link_data_i;
  logic                    link_ready_o;

  modport slave (
    input  host_v_i, host_data_i, host_yumi_i, link_ready_i, link_v_i, link_data_i,
    output host_ready_o, host_v_o, host_data_o, link_v_o, link_data_o, link_ready_o
  );

  modport master (
    output host_v_i, host_data_i, host_yumi_i, link_ready_i, link_v_i, link_data_i,
    input  host_ready_o, host_v_o, host_data_o, link_v_o, link_data_o, link_ready_o
  );
endinterface

// File: rtl/mcl_host_endpoint.sv
// mcl_host_endpoint
//   Host-side endpoint of one manycore link. Host request packets are buffered in a
//   request FIFO and issued to the link only while credits are available; each issue
//   consumes a credit. Link responses are buffered in a response FIFO and handed to
//   the host on a valid/yumi interface; each consumed response returns a credit.
//
//   Ports
//     clk_i, reset_i : clock, asynchronous active-high reset
//     bus            : mcl_host_endpoint_if.slave (host request/response, link
//                      request/response handshakes)
//     credits_o      : credits currently available (max_credits_p after reset)
//     error_o        : sticky protocol error (yumi without valid, or a response
//                      accepted while no request is outstanding)
//     req_count_o    : issued link requests, wraps at 2^32   (MCL_ENDPOINT_COUNTERS_EN)
//     resp_count_o   : accepted link responses, wraps at 2^32 (MCL_ENDPOINT_COUNTERS_EN)
//
//   Optional feature: define MCL_ENDPOINT_COUNTERS_EN to add the two counter ports.
//
//   Both FIFOs track occupancy with a count, so every slot is usable. Ready is taken
//   from the pre-dequeue state: a full FIFO refuses an enqueue even if it dequeues in
//   the same cycle. Outputs are driven only from registered state (no bypass), so a
//   packet enqueued in cycle N is visible at the far side in N+1 at the earliest.
module mcl_host_endpoint #(
  parameter int data_width_p  = 80,
  parameter int req_els_p     = 4,
  parameter int resp_els_p    = 4,
  parameter int max_credits_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  mcl_host_endpoint_if.slave                   bus,
  output logic [$clog2(max_credits_p+1)-1:0]   credits_o,
  output logic                                 error_o
`ifdef MCL_ENDPOINT_COUNTERS_EN
  ,
  output logic [31:0]                          req_count_o,
  output logic [31:0]                          resp_count_o
`endif
);

  localparam int credit_w_lp   = $clog2(max_credits_p + 1);
  localparam int req_ptr_w_lp  = $clog2(req_els_p);
  localparam int req_cnt_w_lp  = $clog2(req_els_p + 1);
  localparam int resp_ptr_w_lp = $clog2(resp_els_p);
  localparam int resp_cnt_w_lp = $clog2(resp_els_p + 1);

  // Elaboration-time parameter checks.
  if (req_els_p < 2) begin : g_bad_req_els
    $error("mcl_host_endpoint: req_els_p must be >= 2");
  end
  if (resp_els_p < 2) begin : g_bad_resp_els
    $error("mcl_host_endpoint: resp_els_p must be >= 2");
  end
  if (max_credits_p < 1 || max_credits_p > resp_els_p) begin : g_bad_credits
    $error("mcl_host_endpoint: max_credits_p must be in 1..resp_els_p");
  end

  // ---------------------------------------------------------------------------
  // Request FIFO (host -> link)
  // ---------------------------------------------------------------------------
  logic [data_width_p-1:0] req_mem [req_els_p];
  logic [req_ptr_w_lp-1:0] req_wr_ptr_r, req_rd_ptr_r;
  logic [req_cnt_w_lp-1:0] req_cnt_r;
  logic                    req_full, req_empty, req_enq, req_deq;

  // ---------------------------------------------------------------------------
  // Response FIFO (link -> host)
  // ---------------------------------------------------------------------------
  logic [data_width_p-1:0]  resp_mem [resp_els_p];
  logic [resp_ptr_w_lp-1:0] resp_wr_ptr_r, resp_rd_ptr_r;
  logic [resp_cnt_w_lp-1:0] resp_cnt_r;
  logic                     resp_full, resp_empty, resp_enq, resp_deq;

  logic [credit_w_lp-1:0] credits_r;
  logic                   credits_at_max;
  logic                   error_r, error_set;
  logic                   link_v;

  assign req_full   = (req_cnt_r == req_cnt_w_lp'(req_els_p));
  assign req_empty  = (req_cnt_r == '0);
  assign resp_full  = (resp_cnt_r == resp_cnt_w_lp'(resp_els_p));
  assign resp_empty = (resp_cnt_r == '0);

  assign credits_at_max = (credits_r == credit_w_lp'(max_credits_p));

  // A request is only offered to the link while a credit is available.
  assign link_v   = ~req_empty & (credits_r != '0);

  assign req_enq  = bus.host_v_i & ~req_full;
  assign req_deq  = link_v & bus.link_ready_i;
  assign resp_enq = bus.link_v_i & ~resp_full;
  // Yumi with an empty response FIFO is a protocol error and does not pop.
  assign resp_deq = bus.host_yumi_i & ~resp_empty;

  assign error_set = (bus.host_yumi_i & resp_empty) | (resp_enq & credits_at_max);

  // Storage has no reset; the data outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (req_enq) req_mem[req_wr_ptr_r] <= bus.host_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (resp_enq) resp_mem[resp_wr_ptr_r] <= bus.link_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_wr_ptr_r <= '0;
      req_rd_ptr_r <= '0;
      req_cnt_r    <= '0;
    end else begin
      if (req_enq) begin
        req_wr_ptr_r <= (req_wr_ptr_r == req_ptr_w_lp'(req_els_p - 1)) ? '0
                        : req_wr_ptr_r + req_ptr_w_lp'(1);
      end
      if (req_deq) begin
        req_rd_ptr_r <= (req_rd_ptr_r == req_ptr_w_lp'(req_els_p - 1)) ? '0
                        : req_rd_ptr_r + req_ptr_w_lp'(1);
      end
      if (req_enq & ~req_deq)      req_cnt_r <= req_cnt_r + req_cnt_w_lp'(1);
      else if (~req_enq & req_deq) req_cnt_r <= req_cnt_r - req_cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_wr_ptr_r <= '0;
      resp_rd_ptr_r <= '0;
      resp_cnt_r    <= '0;
    end else begin
      if (resp_enq) begin
        resp_wr_ptr_r <= (resp_wr_ptr_r == resp_ptr_w_lp'(resp_els_p - 1)) ? '0
                         : resp_wr_ptr_r + resp_ptr_w_lp'(1);
      end
      if (resp_deq) begin
        resp_rd_ptr_r <= (resp_rd_ptr_r == resp_ptr_w_lp'(resp_els_p - 1)) ? '0
                         : resp_rd_ptr_r + resp_ptr_w_lp'(1);
      end
      if (resp_enq & ~resp_deq)      resp_cnt_r <= resp_cnt_r + resp_cnt_w_lp'(1);
      else if (~resp_enq & resp_deq) resp_cnt_r <= resp_cnt_r - resp_cnt_w_lp'(1);
    end
  end

  // Credits: issue takes one, a consumed response gives one back. Both in the same
  // cycle cancel. A return at the maximum (only possible after a spurious
  // response) saturates instead of wrapping. Issue never happens at zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r <= credit_w_lp'(max_credits_p);
    end else if (req_deq & ~resp_deq) begin
      credits_r <= credits_r - credit_w_lp'(1);
    end else if (resp_deq & ~req_deq & ~credits_at_max) begin
      credits_r <= credits_r + credit_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) error_r <= 1'b0;
    else if (error_set) error_r <= 1'b1;
  end

`ifdef MCL_ENDPOINT_COUNTERS_EN
  logic [31:0] req_count_r, resp_count_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_count_r  <= '0;
      resp_count_r <= '0;
    end else begin
      if (req_deq)  req_count_r  <= req_count_r + 32'd1;
      if (resp_enq) resp_count_r <= resp_count_r + 32'd1;
    end
  end

  assign req_count_o  = req_count_r;
  assign resp_count_o = resp_count_r;
`endif

  // Handshake outputs are forced low while reset is held, data outputs to zero.
  assign bus.host_ready_o = ~reset_i & ~req_full;
  assign bus.link_v_o     = ~reset_i & link_v;
  assign bus.link_data_o  = (reset_i | req_empty) ? '0 : req_mem[req_rd_ptr_r];
  assign bus.link_ready_o = ~reset_i & ~resp_full;
  assign bus.host_v_o     = ~reset_i & ~resp_empty;
  assign bus.host_data_o  = (reset_i | resp_empty) ? '0 : resp_mem[resp_rd_ptr_r];
  assign credits_o        = credits_r;
  assign error_o          = error_r;

endmodule

// File: tb/tb_mcl_host_endpoint.sv
// tb_mcl_host_endpoint
//   Self-checking bench for mcl_host_endpoint (default parameters: 80-bit packets,
//   4-deep FIFOs, 4 credits). Inputs change 1 ns after the rising edge; outputs are
//   sampled on the falling edge. Define MCL_ENDPOINT_COUNTERS_EN for both the
//   design and the bench to cover the counter ports.
module tb_mcl_host_endpoint;

  localparam int W    = 80;
  localparam int MAXC = 4;
  localparam int DEPTH = 4;
  localparam int CW   = $clog2(MAXC + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  mcl_host_endpoint_if #(.data_width_p(W)) bus ();
  logic [CW-1:0] credits;
  logic          error;
`ifdef MCL_ENDPOINT_COUNTERS_EN
  logic [31:0]   req_count, resp_count;
`endif

  mcl_host_endpoint #(
    .data_width_p (W),
    .req_els_p    (DEPTH),
    .resp_els_p   (DEPTH),
    .max_credits_p(MAXC)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .bus      (bus),
    .credits_o(credits),
    .error_o  (error)
`ifdef MCL_ENDPOINT_COUNTERS_EN
    ,
    .req_count_o (req_count),
    .resp_count_o(resp_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver / check tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hv, input logic [W-1:0] hd, input logic lr,
                       input logic lv, input logic [W-1:0] ld, input logic yumi);
    bus.host_v_i     = hv;
    bus.host_data_i  = hd;
    bus.link_ready_i = lr;
    bus.link_v_i     = lv;
    bus.link_data_i  = ld;
    bus.host_yumi_i  = yumi;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          hv;
    logic [15:0]   hd;
    logic          lr;
    logic          lv;
    logic [15:0]   ld;
    logic          yumi;
    logic          e_hready;
    logic          e_lv;
    logic [15:0]   e_ld;
    logic          e_hv;
    logic [15:0]   e_hd;
    logic [CW-1:0] e_cred;
  } vec_t;

  function automatic vec_t mk(input logic hv, input logic [15:0] hd, input logic lr,
                              input logic lv, input logic [15:0] ld, input logic yumi,
                              input logic e_hready, input logic e_lv, input logic [15:0] e_ld,
                              input logic e_hv, input logic [15:0] e_hd, input int e_cred);
    vec_t v;
    v.hv = hv; v.hd = hd; v.lr = lr; v.lv = lv; v.ld = ld; v.yumi = yumi;
    v.e_hready = e_hready; v.e_lv = e_lv; v.e_ld = e_ld;
    v.e_hv = e_hv; v.e_hd = e_hd; v.e_cred = CW'(e_cred);
    return v;
  endfunction

  vec_t vecs[17];

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model for the random phase
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];       // requests waiting to go to the link
  logic [W-1:0] resp_exp_q[$];  // responses waiting for the host
  int           m_credits;
  bit           m_error;
  int unsigned  m_req_cnt, m_resp_cnt;

  task automatic run_random(input int cycles);
    logic         hv, lr, lv, yumi;
    logic [W-1:0] hd, ld;
    bit           e_hready, e_lv, e_hv, e_lready, issue, ret;
    int           unresp, p_host, p_link, p_resp, p_yumi;
    exp_q.delete();
    resp_exp_q.delete();
    m_credits = MAXC; m_error = 0; m_req_cnt = 0; m_resp_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      // Change traffic mix every 400 cycles to reach both full FIFO and credit starvation.
      if (c % 400 == 0) begin
        p_host = $urandom_range(20, 95);
        p_link = $urandom_range(10, 95);
        p_resp = $urandom_range(10, 95);
        p_yumi = $urandom_range(10, 95);
      end
      e_hready = exp_q.size() < DEPTH;
      e_lv     = (exp_q.size() > 0) && (m_credits > 0);
      e_hv     = resp_exp_q.size() > 0;
      e_lready = resp_exp_q.size() < DEPTH;
      unresp   = MAXC - m_credits - resp_exp_q.size();

      hv   = ($urandom_range(0, 99) < p_host);
      hd   = rand_data();
      lr   = ($urandom_range(0, 99) < p_link);
      lv   = (unresp > 0) && ($urandom_range(0, 99) < p_resp);
      ld   = rand_data();
      yumi = e_hv && ($urandom_range(0, 99) < p_yumi);
      drive(hv, hd, lr, lv, ld, yumi);
      settle();

      check("rnd host_ready", W'(bus.host_ready_o), W'(e_hready));
      check("rnd link_v", W'(bus.link_v_o), W'(e_lv));
      if (e_lv) check("rnd link_data", bus.link_data_o, exp_q[0]);
      check("rnd host_v", W'(bus.host_v_o), W'(e_hv));
      if (e_hv) check("rnd host_data", bus.host_data_o, resp_exp_q[0]);
      check("rnd link_ready", W'(bus.link_ready_o), W'(e_lready));
      check("rnd credits", W'(credits), W'(m_credits));
      check("rnd error", W'(error), W'(m_error));
`ifdef MCL_ENDPOINT_COUNTERS_EN
      check("rnd req_count", W'(req_count), W'(m_req_cnt));
      check("rnd resp_count", W'(resp_count), W'(m_resp_cnt));
`endif

      issue = e_lv && lr;
      ret   = yumi && e_hv;
      if (issue) begin
        void'(exp_q.pop_front());
        m_req_cnt++;
      end
      if (hv && e_hready) exp_q.push_back(hd);
      if (yumi && !e_hv) m_error = 1;
      if (ret) void'(resp_exp_q.pop_front());
      if (lv && e_lready) begin
        if (m_credits == MAXC) m_error = 1;
        resp_exp_q.push_back(ld);
        m_resp_cnt++;
      end
      m_credits = m_credits - int'(issue) + int'(ret);
      if (m_credits > MAXC) m_credits = MAXC;
      tick();
    end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    //                 hv  hd       lr  lv  ld       yu   hrdy lv  ld       hv  hd       cred
    vecs[0]  = mk(1, 16'h1234, 1, 0, 16'h0,    0,   1, 0, 16'h0,    0, 16'h0,    4);
    vecs[1]  = mk(0, 16'h0,    1, 0, 16'h0,    0,   1, 1, 16'h1234, 0, 16'h0,    4);
    vecs[2]  = mk(0, 16'h0,    0, 1, 16'hBEEF, 0,   1, 0, 16'h0,    0, 16'h0,    3);
    vecs[3]  = mk(1, 16'hA001, 0, 0, 16'h0,    1,   1, 0, 16'h0,    1, 16'hBEEF, 3);
    vecs[4]  = mk(1, 16'hA002, 0, 0, 16'h0,    0,   1, 1, 16'hA001, 0, 16'h0,    4);
    vecs[5]  = mk(1, 16'hA003, 0, 0, 16'h0,    0,   1, 1, 16'hA001, 0, 16'h0,    4);
    vecs[6]  = mk(1, 16'hA004, 0, 0, 16'h0,    0,   1, 1, 16'hA001, 0, 16'h0,    4);
    vecs[7]  = mk(1, 16'hA005, 0, 0, 16'h0,    0,   0, 1, 16'hA001, 0, 16'h0,    4);
    vecs[8]  = mk(1, 16'hA006, 0, 0, 16'h0,    0,   0, 1, 16'hA001, 0, 16'h0,    4);
    vecs[9]  = mk(0, 16'h0,    1, 0, 16'h0,    0,   0, 1, 16'hA001, 0, 16'h0,    4);
    vecs[10] = mk(1, 16'hA0F5, 1, 0, 16'h0,    0,   1, 1, 16'hA002, 0, 16'h0,    3);
    vecs[11] = mk(0, 16'h0,    1, 0, 16'h0,    0,   1, 1, 16'hA003, 0, 16'h0,    2);
    vecs[12] = mk(0, 16'h0,    1, 0, 16'h0,    0,   1, 1, 16'hA004, 0, 16'h0,    1);
    vecs[13] = mk(0, 16'h0,    1, 1, 16'hCAFE, 0,   1, 0, 16'h0,    0, 16'h0,    0);
    vecs[14] = mk(0, 16'h0,    1, 0, 16'h0,    1,   1, 0, 16'h0,    1, 16'hCAFE, 0);
    vecs[15] = mk(0, 16'h0,    1, 0, 16'h0,    0,   1, 1, 16'hA0F5, 0, 16'h0,    1);
    vecs[16] = mk(0, 16'h0,    0, 0, 16'h0,    0,   1, 0, 16'h0,    0, 16'h0,    0);

    // Reset state while reset is held.
    reset_i = 1'b1;
    idle();
    settle();
    check("rst host_ready", W'(bus.host_ready_o), '0);
    check("rst link_v", W'(bus.link_v_o), '0);
    check("rst host_v", W'(bus.host_v_o), '0);
    check("rst link_ready", W'(bus.link_ready_o), '0);
    check("rst link_data", bus.link_data_o, '0);
    check("rst host_data", bus.host_data_o, '0);
    check("rst credits", W'(credits), W'(MAXC));
    check("rst error", W'(error), '0);
    do_reset();

    // Scenarios 1-3 from the table.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].hv, W'(vecs[i].hd), vecs[i].lr, vecs[i].lv, W'(vecs[i].ld), vecs[i].yumi);
      settle();
      check($sformatf("vec%0d host_ready", i), W'(bus.host_ready_o), W'(vecs[i].e_hready));
      check($sformatf("vec%0d link_v", i), W'(bus.link_v_o), W'(vecs[i].e_lv));
      if (vecs[i].e_lv)
        check($sformatf("vec%0d link_data", i), bus.link_data_o, W'(vecs[i].e_ld));
      check($sformatf("vec%0d host_v", i), W'(bus.host_v_o), W'(vecs[i].e_hv));
      if (vecs[i].e_hv)
        check($sformatf("vec%0d host_data", i), bus.host_data_o, W'(vecs[i].e_hd));
      check($sformatf("vec%0d credits", i), W'(credits), W'(vecs[i].e_cred));
      check($sformatf("vec%0d link_ready", i), W'(bus.link_ready_o), W'(1'b1));
      check($sformatf("vec%0d error", i), W'(error), '0);
      tick();
    end
    idle();

    // Scenario 4: response arrives in the same cycle a request issues at credits=2.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(16'hB000 + i), 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    tick();
    drive(1'b0, '0, 1'b1, 1'b1, W'(80'hD00D_0000_0000_0000_1111), 1'b0);
    settle();
    check("s4 credits before", W'(credits), W'(2));
    check("s4 link_v", W'(bus.link_v_o), W'(1'b1));
    check("s4 link_data", bus.link_data_o, W'(16'hB002));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    settle();
    check("s4 host_v", W'(bus.host_v_o), W'(1'b1));
    check("s4 host_data", bus.host_data_o, W'(80'hD00D_0000_0000_0000_1111));
    check("s4 credits mid", W'(credits), W'(1));
    tick();
    idle();
    settle();
    check("s4 credits after", W'(credits), W'(2));
    check("s4 host_v after", W'(bus.host_v_o), '0);
    check("s4 error", W'(error), '0);
    tick();

    // Scenario 5a: spurious response at full credits.
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b1, W'(16'h5555), 1'b0);
    settle();
    check("s5 error before", W'(error), '0);
    tick();
    idle();
    settle();
    check("s5 spurious error", W'(error), W'(1'b1));
    check("s5 spurious enqueued", W'(bus.host_v_o), W'(1'b1));
    check("s5 spurious data", bus.host_data_o, W'(16'h5555));
    repeat (3) tick();
    settle();
    check("s5 error held", W'(error), W'(1'b1));
    tick();

    // Scenario 5b: yumi with nothing valid.
    do_reset();
    settle();
    check("s5 error cleared", W'(error), '0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    idle();
    settle();
    check("s5 yumi error", W'(error), W'(1'b1));
    check("s5 yumi credits", W'(credits), W'(MAXC));
    check("s5 yumi host_v", W'(bus.host_v_o), '0);
    tick();

    // Scenario 6: reset with 3 requests queued and 2 outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(16'hC000 + i), 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    tick();
    drive(1'b1, W'(16'hC0FF), 1'b0, 1'b0, '0, 1'b0);
    tick();
    idle();
    settle();
    check("s6 credits loaded", W'(credits), W'(2));
    check("s6 link_v loaded", W'(bus.link_v_o), W'(1'b1));
    check("s6 link_data loaded", bus.link_data_o, W'(16'hC002));
`ifdef MCL_ENDPOINT_COUNTERS_EN
    check("s6 req_count loaded", W'(req_count), W'(2));
`endif
    reset_i = 1'b1;
    #1;
    check("s6 rst host_ready", W'(bus.host_ready_o), '0);
    check("s6 rst link_v", W'(bus.link_v_o), '0);
    check("s6 rst host_v", W'(bus.host_v_o), '0);
    check("s6 rst link_ready", W'(bus.link_ready_o), '0);
    check("s6 rst link_data", bus.link_data_o, '0);
    check("s6 rst credits", W'(credits), W'(MAXC));
    tick();
    reset_i = 1'b0;
    settle();
    check("s6 post credits", W'(credits), W'(MAXC));
    check("s6 post link_v", W'(bus.link_v_o), '0);
    check("s6 post host_ready", W'(bus.host_ready_o), W'(1'b1));
    check("s6 post host_v", W'(bus.host_v_o), '0);
`ifdef MCL_ENDPOINT_COUNTERS_EN
    check("s6 post req_count", W'(req_count), '0);
    check("s6 post resp_count", W'(resp_count), '0);
`endif
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
